sc_framebuffer_scan: RTL and testbench
======================================

# sc_framebuffer_scan

Double-buffered, parametrised frame buffer for cascaded MAX7219 8x8 LED matrices. The game logic writes rows into a back bank while the display side reads the front bank. A swap request exchanges the banks, either immediately or at the driver's frame boundary, so the display never tears. The block sits between the game state/level logic and the matrix driver, replacing the fixed register set and the combinational row/column mux. It adds bank swap, bulk clear and multi-matrix support.

## Interface
- NUM_MATRICES, 1: number of cascaded 8x8 matrices (1..8).
- TRANSPOSE, 1: 1 = driver row r receives stored column r; 0 = stored row r is passed straight through.
- SYNC_SWAP, 1: 1 = swap waits for FrameSync_In; 0 = swap happens on the cycle after the request.
- MIDX_W, 3: width of the matrix index (must satisfy 2^MIDX_W ≥ NUM_MATRICES).

Ports:
- SC_FRAMEBUF_CLOCK_50  in  1  system clock.
- SC_FRAMEBUF_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_FRAMEBUF_WrEn_InHigh  in  1  writes one row into the back bank.
- SC_FRAMEBUF_WrMatrix_InBus  in  MIDX_W  target matrix index.
- SC_FRAMEBUF_WrRow_InBus  in  3  target row 0..7.
- SC_FRAMEBUF_WrData_InBus  in  8  row pixels, bit 7 = leftmost.
- SC_FRAMEBUF_Clear_InHigh  in  1  request to zero the whole back bank.
- SC_FRAMEBUF_Swap_InHigh  in  1  request to exchange front and back banks.
- SC_FRAMEBUF_FrameSync_InHigh  in  1  one-cycle pulse from the driver at the end of a full 8-row refresh.
- SC_FRAMEBUF_RdAddr_InBus  in  3  driver row address (disp_addr).
- SC_FRAMEBUF_RdData_OutBus  out  8*NUM_MATRICES  front-bank row data; matrix k occupies bits [8k+7:8k].
- SC_FRAMEBUF_Busy_Out  out  1  high while state ≠ IDLE.
- SC_FRAMEBUF_SwapDone_Out  out  1  one-cycle pulse on the cycle the banks exchange.
- SC_FRAMEBUF_FrontBank_Out  out  1  index of the current front bank.

## Operation
- Storage: 2 banks × NUM_MATRICES × 8 rows × 8 bits, held in flops.
- Write: when WrEn is high, state ≠ CLEAR and WrMatrix < NUM_MATRICES, store WrData at back[WrMatrix][WrRow].
  - All other writes are silently dropped.
  - Writes are accepted in IDLE and SWAP_PEND.
- Read with TRANSPOSE=1, for matrix k and row address a: output bit (7−j) = front[k][j] bit (7−a), for j = 0..7.
- Read with TRANSPOSE=0: output = front[k][a].
- FSM states IDLE, CLEAR, SWAP_PEND:
  - IDLE + Clear → CLEAR, with row counter = 0.
    - If Swap is high in the same cycle, it is latched in swap_req.
    - Any write issued in that same cycle is dropped.
  - IDLE + Swap (no Clear):
    - SYNC_SWAP=0: swap on the next edge, then stay in IDLE.
    - SYNC_SWAP=1: go to SWAP_PEND.
  - CLEAR: zero back[all matrices][row counter], then increment the counter.
    - After row 7 is cleared, go to SWAP_PEND if swap_req is set (SYNC_SWAP=1), swap immediately if swap_req is set (SYNC_SWAP=0), otherwise return to IDLE.
    - A Swap request arriving during CLEAR sets swap_req.
    - Clear requests arriving during CLEAR are ignored.
  - SWAP_PEND + FrameSync → swap, return to IDLE.
    - Clear and extra Swap requests in SWAP_PEND are ignored.
- Swap action: toggle FrontBank, pulse SwapDone for one cycle, clear swap_req.
  - The old front bank becomes the new back bank, contents retained.
- A write in the same cycle as a swap goes to the pre-swap back bank and therefore becomes visible.
- FrameSync outside SWAP_PEND has no effect.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - Both banks are zero, FrontBank=0, state=IDLE, swap_req=0.
  - RdData=0, Busy=0, SwapDone=0.
- Reset mid-CLEAR or mid-SWAP_PEND aborts the operation; no swap occurs.
- RdData is registered: data for RdAddr sampled at edge n appears after edge n, i.e. 1-cycle latency.
  - The read reflects the bank that is front at edge n.
- A write becomes readable 1 cycle after the swap that publishes it.
- CLEAR lasts exactly 8 cycles. Busy rises the cycle after the Clear request.
- Swap latency:
  - SYNC_SWAP=0: 1 cycle after the request.
  - SYNC_SWAP=1: 1 cycle after the first FrameSync seen in SWAP_PEND.

## Structure
- The shared package holds:
  - FSM state typedef (IDLE/CLEAR/SWAP_PEND).
  - Constants MATRIX_ROWS=8 and MATRIX_COLS=8.
  - Transpose function (row array in, column byte out), reusable by other display blocks.
- A single sub-module sc_framebuf_bank (one bank: write port, synchronous row clear, combinational read of all rows) is instantiated twice.

## Test plan
- Reset, then write 8'b00010000 to m0 row 7, Swap (SYNC_SWAP=0), read RdAddr=3 with TRANSPOSE=1 → RdData=8'b00000001 one cycle later; SwapDone pulses once; FrontBank=1.
- SYNC_SWAP=1: assert Swap, then hold FrameSync low for 50 cycles → FrontBank unchanged and Busy=1 throughout; pulse FrameSync → swap on the next edge and Busy=0.
- Fill back bank with 8'hFF, assert Clear and Swap together → writes during the 8 CLEAR cycles dropped; after swap, all reads = 0.
- NUM_MATRICES=2: write 8'hA5 to m1 row 0 and 8'h3C to m0 row 0, swap, TRANSPOSE=0, RdAddr=0 → RdData=16'hA53C; a write with WrMatrix=2 leaves storage unchanged.
- Assert reset during CLEAR cycle 4 → all outputs 0, FrontBank=0, no SwapDone after release.
- Write and swap in the same cycle → the written row is visible in the new front bank; the old front contents are intact in the new back bank (verified by a second swap).

Source files
------------

// File: rtl/sc_framebuffer_scan_pkg.sv
// sc_framebuffer_scan_pkg: shared FSM state, matrix geometry and the row-to-column
// transpose used by MAX7219 display blocks.
package sc_framebuffer_scan_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_SWAP_PEND} state_t;

    typedef logic [MATRIX_COLS-1:0] row_t;

    // Column col of an 8x8 image as a byte; row j lands on bit (7-j), col 0 is the leftmost pixel.
    function automatic row_t transpose_col(
        input logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0] rows,
        input logic [2:0] col
    );
        row_t col_byte;
        col_byte = '0;
        for (int j = 0; j < MATRIX_ROWS; j++)
            col_byte[MATRIX_COLS-1-j] = rows[j][~col];
        return col_byte;
    endfunction

endpackage

// File: rtl/sc_framebuffer_scan_if.sv
// sc_framebuffer_scan_if: write/control/read bus between game logic, matrix driver and the frame buffer.
interface sc_framebuffer_scan_if #(
    parameter int NUM_MATRICES = 1,
    parameter int MIDX_W       = 3
) ();

    logic                      SC_FRAMEBUF_WrEn_InHigh;
    logic [MIDX_W-1:0]         SC_FRAMEBUF_WrMatrix_InBus;
    logic [2:0]                SC_FRAMEBUF_WrRow_InBus;
    logic [7:0]                SC_FRAMEBUF_WrData_InBus;
    logic                      SC_FRAMEBUF_Clear_InHigh;
    logic                      SC_FRAMEBUF_Swap_InHigh;
    logic                      SC_FRAMEBUF_FrameSync_InHigh;
    logic [2:0]                SC_FRAMEBUF_RdAddr_InBus;
    logic [8*NUM_MATRICES-1:0] SC_FRAMEBUF_RdData_OutBus;
    logic                      SC_FRAMEBUF_Busy_Out;
    logic                      SC_FRAMEBUF_SwapDone_Out;
    logic                      SC_FRAMEBUF_FrontBank_Out;

    modport master (
        output SC_FRAMEBUF_WrEn_InHigh, SC_FRAMEBUF_WrMatrix_InBus, SC_FRAMEBUF_WrRow_InBus,
               SC_FRAMEBUF_WrData_InBus, SC_FRAMEBUF_Clear_InHigh, SC_FRAMEBUF_Swap_InHigh,
               SC_FRAMEBUF_FrameSync_InHigh, SC_FRAMEBUF_RdAddr_InBus,
        input  SC_FRAMEBUF_RdData_OutBus, SC_FRAMEBUF_Busy_Out, SC_FRAMEBUF_SwapDone_Out,
               SC_FRAMEBUF_FrontBank_Out
    );

    modport slave (
        input  SC_FRAMEBUF_WrEn_InHigh, SC_FRAMEBUF_WrMatrix_InBus, SC_FRAMEBUF_WrRow_InBus,
               SC_FRAMEBUF_WrData_InBus, SC_FRAMEBUF_Clear_InHigh, SC_FRAMEBUF_Swap_InHigh,
               SC_FRAMEBUF_FrameSync_InHigh, SC_FRAMEBUF_RdAddr_InBus,
        output SC_FRAMEBUF_RdData_OutBus, SC_FRAMEBUF_Busy_Out, SC_FRAMEBUF_SwapDone_Out,
               SC_FRAMEBUF_FrontBank_Out
    );

endinterface

// File: rtl/sc_framebuf_bank.sv
// sc_framebuf_bank: one pixel bank of NUM_MATRICES 8x8 images with a row write port,
// a synchronous all-matrix row clear and a flat view of every row.
module sc_framebuf_bank
    import sc_framebuffer_scan_pkg::*;
#(
    parameter int NUM_MATRICES = 1,
    parameter int MIDX_W       = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [MIDX_W-1:0] i_wr_matrix,
    input  logic [2:0]        i_wr_row,
    input  row_t              i_wr_data,
    input  logic              i_clr,
    input  logic [2:0]        i_clr_row,
    output logic [NUM_MATRICES-1:0][MATRIX_ROWS-1:0][MATRIX_COLS-1:0] o_rows
);

    logic [NUM_MATRICES-1:0][MATRIX_ROWS-1:0][MATRIX_COLS-1:0] r_mem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '0;
        end else begin
            for (int m = 0; m < NUM_MATRICES; m++) begin
                if (i_clr)
                    r_mem[m][i_clr_row] <= '0;
                else if (i_we && 32'(i_wr_matrix) == m)
                    r_mem[m][i_wr_row] <= i_wr_data;
            end
        end
    end

    assign o_rows = r_mem;

endmodule

// File: rtl/sc_framebuffer_scan.sv
// sc_framebuffer_scan: double-buffered MAX7219 frame buffer; game logic fills the back bank,
// the driver reads the front bank, and swaps happen immediately or at the driver frame boundary.
module sc_framebuffer_scan
    import sc_framebuffer_scan_pkg::*;
#(
    parameter int NUM_MATRICES = 1,
    parameter int TRANSPOSE    = 1,
    parameter int SYNC_SWAP    = 1,
    parameter int MIDX_W       = 3
) (
    input  logic SC_FRAMEBUF_CLOCK_50,
    input  logic SC_FRAMEBUF_RESET_InLow,
    sc_framebuffer_scan_if.slave bus
);

    typedef logic [NUM_MATRICES-1:0][MATRIX_ROWS-1:0][MATRIX_COLS-1:0] bank_t;

    state_t                    r_state, w_state_nxt;
    logic [2:0]                r_cnt;
    logic                      r_swap_req, r_front, r_swap_done;
    logic [8*NUM_MATRICES-1:0] r_rd, w_rd;
    logic                      w_swap, w_wr, w_req, w_req_set, w_last;
    bank_t                     w_rows [2];
    bank_t                     w_front;

    assign w_req  = r_swap_req || bus.SC_FRAMEBUF_Swap_InHigh;
    assign w_last = r_cnt == 3'd7;

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        w_req_set   = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr        = !bus.SC_FRAMEBUF_Clear_InHigh;
                w_req_set   = bus.SC_FRAMEBUF_Clear_InHigh && bus.SC_FRAMEBUF_Swap_InHigh;
                w_swap      = !bus.SC_FRAMEBUF_Clear_InHigh && bus.SC_FRAMEBUF_Swap_InHigh && SYNC_SWAP == 0;
                w_state_nxt = bus.SC_FRAMEBUF_Clear_InHigh ? ST_CLEAR :
                              (bus.SC_FRAMEBUF_Swap_InHigh && SYNC_SWAP != 0) ? ST_SWAP_PEND : ST_IDLE;
            end
            ST_CLEAR: begin
                w_req_set   = bus.SC_FRAMEBUF_Swap_InHigh;
                w_swap      = w_last && w_req && SYNC_SWAP == 0;
                w_state_nxt = !w_last ? ST_CLEAR : (w_req && SYNC_SWAP != 0) ? ST_SWAP_PEND : ST_IDLE;
            end
            ST_SWAP_PEND: begin
                w_wr        = 1'b1;
                w_swap      = bus.SC_FRAMEBUF_FrameSync_InHigh;
                w_state_nxt = bus.SC_FRAMEBUF_FrameSync_InHigh ? ST_IDLE : ST_SWAP_PEND;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_wr = w_wr && bus.SC_FRAMEBUF_WrEn_InHigh && 32'(bus.SC_FRAMEBUF_WrMatrix_InBus) < NUM_MATRICES;
    end

    always_ff @(posedge SC_FRAMEBUF_CLOCK_50 or negedge SC_FRAMEBUF_RESET_InLow) begin
        if (!SC_FRAMEBUF_RESET_InLow) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_swap_req  <= 1'b0;
            r_front     <= 1'b0;
            r_swap_done <= 1'b0;
            r_rd        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= (r_state == ST_CLEAR) ? r_cnt + 3'd1 : 3'd0;
            r_swap_req  <= !w_swap && (r_swap_req || w_req_set);
            r_front     <= r_front ^ w_swap;
            r_swap_done <= w_swap;
            r_rd        <= w_rd;
        end
    end

    // Bank b is the back bank whenever the front index points at the other one.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        sc_framebuf_bank #(
            .NUM_MATRICES(NUM_MATRICES),
            .MIDX_W      (MIDX_W)
        ) u_bank (
            .i_clk      (SC_FRAMEBUF_CLOCK_50),
            .i_rst_n    (SC_FRAMEBUF_RESET_InLow),
            .i_we       (w_wr && (r_front == (b == 0))),
            .i_wr_matrix(bus.SC_FRAMEBUF_WrMatrix_InBus),
            .i_wr_row   (bus.SC_FRAMEBUF_WrRow_InBus),
            .i_wr_data  (bus.SC_FRAMEBUF_WrData_InBus),
            .i_clr      (r_state == ST_CLEAR && (r_front == (b == 0))),
            .i_clr_row  (r_cnt),
            .o_rows     (w_rows[b])
        );
    end

    assign w_front = r_front ? w_rows[1] : w_rows[0];

    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NUM_MATRICES; k++)
            w_rd[8*k +: 8] = TRANSPOSE != 0 ? transpose_col(w_front[k], bus.SC_FRAMEBUF_RdAddr_InBus)
                                            : w_front[k][bus.SC_FRAMEBUF_RdAddr_InBus];
    end

    assign bus.SC_FRAMEBUF_RdData_OutBus = r_rd;
    assign bus.SC_FRAMEBUF_Busy_Out      = r_state != ST_IDLE;
    assign bus.SC_FRAMEBUF_SwapDone_Out  = r_swap_done;
    assign bus.SC_FRAMEBUF_FrontBank_Out = r_front;

endmodule

// File: tb/tb_sc_framebuffer_scan.sv
// tb_sc_framebuffer_scan: directed bench with two instances, A (1 matrix, transposed, immediate swap)
// and B (2 matrices, straight rows, frame-synchronised swap).
module tb_sc_framebuffer_scan;

    logic clk = 1'b0;
    logic rst_n_a, rst_n_b;
    int   checks = 0;
    int   errors = 0;
    logic bad, seen_sd, seen_fb;

    always #5 clk = ~clk;

    sc_framebuffer_scan_if #(.NUM_MATRICES(1), .MIDX_W(3)) ifa ();
    sc_framebuffer_scan_if #(.NUM_MATRICES(2), .MIDX_W(3)) ifb ();

    sc_framebuffer_scan #(.NUM_MATRICES(1), .TRANSPOSE(1), .SYNC_SWAP(0), .MIDX_W(3)) dut_a (
        .SC_FRAMEBUF_CLOCK_50   (clk),
        .SC_FRAMEBUF_RESET_InLow(rst_n_a),
        .bus                    (ifa)
    );

    sc_framebuffer_scan #(.NUM_MATRICES(2), .TRANSPOSE(0), .SYNC_SWAP(1), .MIDX_W(3)) dut_b (
        .SC_FRAMEBUF_CLOCK_50   (clk),
        .SC_FRAMEBUF_RESET_InLow(rst_n_b),
        .bus                    (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic a_in(input logic we, input logic [2:0] m, input logic [2:0] row, input logic [7:0] d,
                        input logic clr, input logic swp, input logic [2:0] addr);
        ifa.SC_FRAMEBUF_WrEn_InHigh      = we;
        ifa.SC_FRAMEBUF_WrMatrix_InBus   = m;
        ifa.SC_FRAMEBUF_WrRow_InBus      = row;
        ifa.SC_FRAMEBUF_WrData_InBus     = d;
        ifa.SC_FRAMEBUF_Clear_InHigh     = clr;
        ifa.SC_FRAMEBUF_Swap_InHigh      = swp;
        ifa.SC_FRAMEBUF_FrameSync_InHigh = 1'b0;
        ifa.SC_FRAMEBUF_RdAddr_InBus     = addr;
    endtask

    task automatic b_in(input logic we, input logic [2:0] m, input logic [2:0] row, input logic [7:0] d,
                        input logic clr, input logic swp, input logic fs, input logic [2:0] addr);
        ifb.SC_FRAMEBUF_WrEn_InHigh      = we;
        ifb.SC_FRAMEBUF_WrMatrix_InBus   = m;
        ifb.SC_FRAMEBUF_WrRow_InBus      = row;
        ifb.SC_FRAMEBUF_WrData_InBus     = d;
        ifb.SC_FRAMEBUF_Clear_InHigh     = clr;
        ifb.SC_FRAMEBUF_Swap_InHigh      = swp;
        ifb.SC_FRAMEBUF_FrameSync_InHigh = fs;
        ifb.SC_FRAMEBUF_RdAddr_InBus     = addr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        a_in(0, 0, 0, 8'h00, 0, 0, 0);
        b_in(0, 0, 0, 8'h00, 0, 0, 0, 0);
        tick(2);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick();
        chk("a_rst_rd",   32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h0);
        chk("a_rst_busy", 32'(ifa.SC_FRAMEBUF_Busy_Out),      32'h0);
        chk("a_rst_sd",   32'(ifa.SC_FRAMEBUF_SwapDone_Out),  32'h0);
        chk("a_rst_fb",   32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h0);
        chk("b_rst_rd",   32'(ifb.SC_FRAMEBUF_RdData_OutBus), 32'h0);
        chk("b_rst_busy", 32'(ifb.SC_FRAMEBUF_Busy_Out),      32'h0);
        chk("b_rst_fb",   32'(ifb.SC_FRAMEBUF_FrontBank_Out), 32'h0);

        // A: write m0 row7, immediate swap, transposed read of column 3
        a_in(1, 0, 7, 8'h10, 0, 0, 3);
        tick();
        a_in(0, 0, 0, 8'h00, 0, 1, 3);
        tick();
        chk("a_t1_sd",     32'(ifa.SC_FRAMEBUF_SwapDone_Out),  32'h1);
        chk("a_t1_fb",     32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h1);
        chk("a_t1_rd_old", 32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h0);
        a_in(0, 0, 0, 8'h00, 0, 0, 3);
        tick();
        chk("a_t1_rd",     32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h01);
        chk("a_t1_sd_off", 32'(ifa.SC_FRAMEBUF_SwapDone_Out),  32'h0);
        chk("a_t1_fb_hold",32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h1);

        // A: write and swap in the same cycle, then swap back to see the old front
        a_in(1, 0, 2, 8'h81, 0, 1, 0);
        tick();
        chk("a_t6_fb", 32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h0);
        chk("a_t6_sd", 32'(ifa.SC_FRAMEBUF_SwapDone_Out),  32'h1);
        a_in(0, 0, 0, 8'h00, 0, 0, 0);
        tick();
        chk("a_t6_rd_c0", 32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h20);
        a_in(0, 0, 0, 8'h00, 0, 0, 3);
        tick();
        chk("a_t6_rd_c3", 32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h00);
        a_in(0, 0, 0, 8'h00, 0, 1, 3);
        tick();
        chk("a_t6_fb2", 32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h1);
        a_in(0, 0, 0, 8'h00, 0, 0, 3);
        tick();
        chk("a_t6_old_front", 32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h01);

        // A: fill back bank, then Clear+Swap together with writes held on
        for (int r = 0; r < 8; r++) begin
            a_in(1, 0, 3'(r), 8'hFF, 0, 0, 3);
            tick();
        end
        a_in(1, 0, 0, 8'hFF, 1, 1, 3);
        tick();
        chk("a_t3_busy_rise", 32'(ifa.SC_FRAMEBUF_Busy_Out),      32'h1);
        chk("a_t3_fb_hold",   32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h1);
        for (int i = 1; i < 8; i++) begin
            a_in(1, 0, 3'(i), 8'hFF, 0, 0, 3);
            tick();
        end
        chk("a_t3_busy_c7", 32'(ifa.SC_FRAMEBUF_Busy_Out),     32'h1);
        chk("a_t3_sd_c7",   32'(ifa.SC_FRAMEBUF_SwapDone_Out), 32'h0);
        a_in(1, 0, 5, 8'hFF, 0, 0, 3);
        tick();
        chk("a_t3_busy_end", 32'(ifa.SC_FRAMEBUF_Busy_Out),      32'h0);
        chk("a_t3_sd",       32'(ifa.SC_FRAMEBUF_SwapDone_Out),  32'h1);
        chk("a_t3_fb",       32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h0);
        for (int a = 0; a < 8; a++) begin
            a_in(0, 0, 0, 8'h00, 0, 0, 3'(a));
            tick();
            chk($sformatf("a_t3_rd%0d", a), 32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h0);
        end

        // A: reset in the middle of a clear aborts it and the pending swap
        a_in(0, 0, 0, 8'h00, 0, 1, 3);
        tick();
        a_in(0, 0, 0, 8'h00, 0, 0, 3);
        tick();
        chk("a_t5_pre_rd", 32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h01);
        chk("a_t5_pre_fb", 32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h1);
        a_in(0, 0, 0, 8'h00, 1, 1, 3);
        tick();
        a_in(0, 0, 0, 8'h00, 0, 0, 3);
        tick(4);
        chk("a_t5_busy_mid", 32'(ifa.SC_FRAMEBUF_Busy_Out), 32'h1);
        rst_n_a = 1'b0;
        #1;
        chk("a_t5_rst_rd",   32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h0);
        chk("a_t5_rst_busy", 32'(ifa.SC_FRAMEBUF_Busy_Out),      32'h0);
        chk("a_t5_rst_sd",   32'(ifa.SC_FRAMEBUF_SwapDone_Out),  32'h0);
        chk("a_t5_rst_fb",   32'(ifa.SC_FRAMEBUF_FrontBank_Out), 32'h0);
        tick();
        rst_n_a = 1'b1;
        seen_sd = 1'b0;
        seen_fb = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen_sd |= ifa.SC_FRAMEBUF_SwapDone_Out;
            seen_fb |= ifa.SC_FRAMEBUF_FrontBank_Out;
        end
        chk("a_t5_no_sd",  32'(seen_sd), 32'h0);
        chk("a_t5_no_fb",  32'(seen_fb), 32'h0);
        chk("a_t5_busy",   32'(ifa.SC_FRAMEBUF_Busy_Out),      32'h0);
        chk("a_t5_rd",     32'(ifa.SC_FRAMEBUF_RdData_OutBus), 32'h0);

        // B: two matrices, out-of-range write, frame-synchronised swap
        b_in(1, 1, 0, 8'hA5, 0, 0, 0, 0);
        tick();
        b_in(1, 0, 0, 8'h3C, 0, 0, 0, 0);
        tick();
        b_in(1, 2, 0, 8'hFF, 0, 0, 0, 0);
        tick();
        b_in(1, 7, 0, 8'h77, 0, 0, 0, 0);
        tick();
        b_in(0, 0, 0, 8'h00, 0, 1, 0, 0);
        tick();
        chk("b_pend_busy", 32'(ifb.SC_FRAMEBUF_Busy_Out),      32'h1);
        chk("b_pend_fb",   32'(ifb.SC_FRAMEBUF_FrontBank_Out), 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            b_in(i == 20, 0, 1, 8'h5A, i == 10, i == 30, 0, 0);
            tick();
            bad |= ifb.SC_FRAMEBUF_FrontBank_Out | ~ifb.SC_FRAMEBUF_Busy_Out | ifb.SC_FRAMEBUF_SwapDone_Out;
        end
        chk("b_pend_hold", 32'(bad), 32'h0);
        b_in(0, 0, 0, 8'h00, 0, 0, 1, 0);
        tick();
        chk("b_sync_sd",   32'(ifb.SC_FRAMEBUF_SwapDone_Out),  32'h1);
        chk("b_sync_fb",   32'(ifb.SC_FRAMEBUF_FrontBank_Out), 32'h1);
        chk("b_sync_busy", 32'(ifb.SC_FRAMEBUF_Busy_Out),      32'h0);
        b_in(0, 0, 0, 8'h00, 0, 0, 0, 0);
        tick();
        chk("b_rd_row0", 32'(ifb.SC_FRAMEBUF_RdData_OutBus), 32'hA53C);
        chk("b_sd_off",  32'(ifb.SC_FRAMEBUF_SwapDone_Out),  32'h0);
        b_in(0, 0, 0, 8'h00, 0, 0, 0, 1);
        tick();
        chk("b_rd_row1", 32'(ifb.SC_FRAMEBUF_RdData_OutBus), 32'h005A);
        b_in(0, 0, 0, 8'h00, 0, 0, 1, 1);
        tick();
        b_in(0, 0, 0, 8'h00, 0, 0, 0, 1);
        tick();
        chk("b_idle_fs_fb",   32'(ifb.SC_FRAMEBUF_FrontBank_Out), 32'h1);
        chk("b_idle_fs_sd",   32'(ifb.SC_FRAMEBUF_SwapDone_Out),  32'h0);
        chk("b_idle_fs_busy", 32'(ifb.SC_FRAMEBUF_Busy_Out),      32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
